// File: rtl/instr_fetch_if.sv
// Fetch/loader bus between the PC, control sequencer, decoder and program store.
// The master side drives address, fetch request and loader writes.
// The slave side (program store) returns the instruction word and status strobes.
interface instr_fetch_if;
    logic [3:0] A;
    logic       FETCH;
    logic       PROG_WE;
    logic [3:0] PROG_ADDR;
    logic [7:0] PROG_DATA;
    logic [7:0] IR;
    logic [3:0] OPCODE;
    logic [3:0] OPERAND;
    logic       READY;
    logic       BUSY;
    logic       PCEN;
    logic       HALT;
    logic       PERR;

    modport master (
        output A, FETCH, PROG_WE, PROG_ADDR, PROG_DATA,
        input  IR, OPCODE, OPERAND, READY, BUSY, PCEN, HALT, PERR
    );

    modport slave (
        input  A, FETCH, PROG_WE, PROG_ADDR, PROG_DATA,
        output IR, OPCODE, OPERAND, READY, BUSY, PCEN, HALT, PERR
    );
endinterface

// File: rtl/instr_fetch.sv
// Program store + instruction register: fetches mem[A] on FETCH, strobes PCEN to advance PC.
// Latency: FETCH accepted at edge 0, IR/READY/PCEN valid after edge 2, idle again after edge 3.
// Backpressure: BUSY high for the whole fetch; FETCH during BUSY or after HALT is dropped.
// Optional parity store enabled by defining IFETCH_PARITY_EN (9-bit words, sticky PERR).
module instr_fetch (
    input  logic        CLK,
    input  logic        RESET,
    instr_fetch_if.slave bus
);

`ifdef IFETCH_PARITY_EN
    localparam int WORD_W = 9;
`else
    localparam int WORD_W = 8;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_LATCH = 2'd2,
        S_STEP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          addr_q, addr_d;
    logic [7:0]          ir_q, ir_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                pcen_q, pcen_d;
    logic                halt_q, halt_d;
`ifdef IFETCH_PARITY_EN
    logic                perr_q, perr_d;
`endif

    // Program store is deliberately not reset; contents survive RESET.
    logic [WORD_W-1:0]   mem_q [16];
    logic [WORD_W-1:0]   rdata_q;

    // Loader writes in any state; the READ-state read uses pre-edge contents.
    always_ff @(posedge CLK) begin
        if (bus.PROG_WE) begin
`ifdef IFETCH_PARITY_EN
            mem_q[bus.PROG_ADDR] <= {^bus.PROG_DATA, bus.PROG_DATA};
`else
            mem_q[bus.PROG_ADDR] <= bus.PROG_DATA;
`endif
        end
        if (state_q == S_READ) begin
            rdata_q <= mem_q[addr_q];
        end
    end

    // Control state and architectural outputs, cleared asynchronously.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            addr_q  <= 4'd0;
            ir_q    <= 8'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            pcen_q  <= 1'b0;
            halt_q  <= 1'b0;
`ifdef IFETCH_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            pcen_q  <= pcen_d;
            halt_q  <= halt_d;
`ifdef IFETCH_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    // Next-state and output-register updates for the four-step fetch sequence.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        pcen_d  = pcen_q;
        halt_d  = halt_q;
`ifdef IFETCH_PARITY_EN
        perr_d  = perr_q;
`endif
        case (state_q)
            S_IDLE: begin
                // A halted core parks here until RESET.
                if (bus.FETCH && !halt_q) begin
                    addr_d  = bus.A;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                state_d = S_STEP;
`ifdef IFETCH_PARITY_EN
                if (^rdata_q) begin
                    // Corrupt word: keep old IR, no PC advance, flag it.
                    perr_d = 1'b1;
                end else
`endif
                begin
                    ir_d    = rdata_q[7:0];
                    ready_d = 1'b1;
                    // HLT leaves the PC pointing at itself.
                    if (rdata_q[7:4] == 4'hF) begin
                        halt_d = 1'b1;
                    end else begin
                        pcen_d = 1'b1;
                    end
                end
            end
            S_STEP: begin
                pcen_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.IR      = ir_q;
    assign bus.OPCODE  = ir_q[7:4];
    assign bus.OPERAND = ir_q[3:0];
    assign bus.READY   = ready_q;
    assign bus.BUSY    = busy_q;
    assign bus.PCEN    = pcen_q;
    assign bus.HALT    = halt_q;
`ifdef IFETCH_PARITY_EN
    assign bus.PERR    = perr_q;
`else
    assign bus.PERR    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: timestamp-based reference model plus literal checks.
// Inputs change on the falling edge, outputs are compared on the falling edge.
// Runs a few hundred cycles and prints one summary line.
module tb_instr_fetch;

    logic CLK;
    logic RESET;
    instr_fetch_if bus ();

    instr_fetch dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a fetch accepted at cycle t reads memory at t+1,
    // publishes results at t+2 and frees the unit at t+3.
    logic [7:0] mem_m [16];
    int         cyc   = 0;
    int         t_acc = -100;
    logic [3:0] m_addr = 4'd0;
    logic [7:0] m_word = 8'd0;
    logic [7:0] m_ir   = 8'd0;
    logic       m_ready = 1'b0;
    logic       m_halt  = 1'b0;

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            t_acc   = -100;
            m_ir    = 8'd0;
            m_ready = 1'b0;
            m_halt  = 1'b0;
        end else begin
            cyc++;
            if (cyc == t_acc + 1) m_word = mem_m[m_addr];
            if (cyc == t_acc + 2) begin
                m_ir    = m_word;
                m_ready = 1'b1;
                if (m_word[7:4] == 4'hF) m_halt = 1'b1;
            end
            if ((cyc - t_acc) > 3 && bus.FETCH && !m_halt) begin
                t_acc   = cyc;
                m_addr  = bus.A;
                m_ready = 1'b0;
            end
            if (bus.PROG_WE) mem_m[bus.PROG_ADDR] = bus.PROG_DATA;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge CLK) begin
        if (!RESET) begin
            logic exp_busy;
            logic exp_pcen;
            exp_busy = (cyc - t_acc) >= 0 && (cyc - t_acc) <= 2;
            exp_pcen = (cyc == t_acc + 2) && (m_word[7:4] != 4'hF);
            chk("m_IR",      {24'd0, bus.IR},      {24'd0, m_ir});
            chk("m_OPCODE",  {28'd0, bus.OPCODE},  {28'd0, m_ir[7:4]});
            chk("m_OPERAND", {28'd0, bus.OPERAND}, {28'd0, m_ir[3:0]});
            chk("m_READY",   {31'd0, bus.READY},   {31'd0, m_ready});
            chk("m_BUSY",    {31'd0, bus.BUSY},    {31'd0, exp_busy});
            chk("m_PCEN",    {31'd0, bus.PCEN},    {31'd0, exp_pcen});
            chk("m_HALT",    {31'd0, bus.HALT},    {31'd0, m_halt});
            chk("m_PERR",    {31'd0, bus.PERR},    32'd0);
        end
    end

    task automatic load(input logic [3:0] addr, input logic [7:0] data);
        @(negedge CLK);
        bus.PROG_WE   = 1'b1;
        bus.PROG_ADDR = addr;
        bus.PROG_DATA = data;
        @(negedge CLK);
        bus.PROG_WE   = 1'b0;
    endtask

    // Single FETCH pulse at address a; returns after edge 3 (unit idle again).
    task automatic fetch_once(input logic [3:0] a);
        @(negedge CLK);
        bus.A     = a;
        bus.FETCH = 1'b1;
        @(negedge CLK);
        bus.FETCH = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    logic [7:0] prog [16];
    logic [7:0] exp_seq [4];
    logic [7:0] got_seq [$];
    int         pulses;
    int         pc;

    initial begin
        RESET = 1'b1;
        bus.A = 4'd0;
        bus.FETCH = 1'b0;
        bus.PROG_WE = 1'b0;
        bus.PROG_ADDR = 4'd0;
        bus.PROG_DATA = 8'd0;

        // Reset values
        repeat (2) @(negedge CLK);
        chk("rst_IR",    {24'd0, bus.IR}, 32'h0);
        chk("rst_READY", {31'd0, bus.READY}, 32'd0);
        chk("rst_BUSY",  {31'd0, bus.BUSY}, 32'd0);
        chk("rst_PCEN",  {31'd0, bus.PCEN}, 32'd0);
        chk("rst_HALT",  {31'd0, bus.HALT}, 32'd0);
        chk("rst_PERR",  {31'd0, bus.PERR}, 32'd0);
        RESET = 1'b0;

        // Program image
        for (int i = 0; i < 16; i++) prog[i] = 8'h60 + 8'(i);
        prog[0] = 8'h12; prog[1] = 8'h34; prog[2] = 8'h56; prog[3] = 8'h2A;
        prog[4] = 8'h4C; prog[5] = 8'hF0; prog[7] = 8'h55;
        for (int i = 0; i < 16; i++) load(4'(i), prog[i]);

        // Basic fetch at A=3
        @(negedge CLK);
        bus.A = 4'd3;
        bus.FETCH = 1'b1;
        @(negedge CLK);
        bus.FETCH = 1'b0;
        chk("f3_BUSY_e0", {31'd0, bus.BUSY}, 32'd1);
        repeat (2) @(negedge CLK);
        chk("f3_IR",      {24'd0, bus.IR}, 32'h2A);
        chk("f3_OPCODE",  {28'd0, bus.OPCODE}, 32'h2);
        chk("f3_OPERAND", {28'd0, bus.OPERAND}, 32'hA);
        chk("f3_READY",   {31'd0, bus.READY}, 32'd1);
        chk("f3_PCEN",    {31'd0, bus.PCEN}, 32'd1);
        @(negedge CLK);
        chk("f3_PCEN_off", {31'd0, bus.PCEN}, 32'd0);
        chk("f3_BUSY_off", {31'd0, bus.BUSY}, 32'd0);
        chk("f3_READY_lvl", {31'd0, bus.READY}, 32'd1);

        // Async reset while in READ aborts the fetch
        @(negedge CLK);
        bus.A = 4'd1;
        bus.FETCH = 1'b1;
        @(negedge CLK);
        bus.FETCH = 1'b0;
        #2 RESET = 1'b1;
        #1;
        chk("ar_IR",    {24'd0, bus.IR}, 32'h0);
        chk("ar_BUSY",  {31'd0, bus.BUSY}, 32'd0);
        chk("ar_READY", {31'd0, bus.READY}, 32'd0);
        chk("ar_PCEN",  {31'd0, bus.PCEN}, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        fetch_once(4'd1);
        chk("ar_refetch_IR", {24'd0, bus.IR}, 32'h34);

        // FETCH held high, PC advancing on PCEN: 4 fetches in 16 cycles
        pc = 0;
        pulses = 0;
        exp_seq[0] = 8'h12; exp_seq[1] = 8'h34; exp_seq[2] = 8'h56; exp_seq[3] = 8'h2A;
        @(negedge CLK);
        bus.A = 4'(pc);
        bus.FETCH = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            if (bus.PCEN) begin
                pulses++;
                got_seq.push_back(bus.IR);
                pc++;
            end
            bus.A = 4'(pc);
        end
        bus.FETCH = 1'b0;
        chk("cont_pulses", 32'(pulses), 32'd4);
        chk("cont_pc", 32'(pc), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("cont_IR_seq", (i < got_seq.size()) ? {24'd0, got_seq[i]} : 32'hFFFF_FFFF,
                {24'd0, exp_seq[i]});
        end
        repeat (3) @(negedge CLK);

        // Loader write to the address being read on the READ edge
        @(negedge CLK);
        bus.A = 4'd7;
        bus.FETCH = 1'b1;
        @(negedge CLK);
        bus.FETCH = 1'b0;
        bus.PROG_WE = 1'b1;
        bus.PROG_ADDR = 4'd7;
        bus.PROG_DATA = 8'h11;
        @(negedge CLK);
        bus.PROG_WE = 1'b0;
        @(negedge CLK);
        chk("rbw_old", {24'd0, bus.IR}, 32'h55);
        @(negedge CLK);
        fetch_once(4'd7);
        chk("rbw_new", {24'd0, bus.IR}, 32'h11);

        // A=15 behaves like any other address
        fetch_once(4'd15);
        chk("a15_IR", {24'd0, bus.IR}, 32'h6F);

        // HLT fetch parks the unit
        pulses = 0;
        @(negedge CLK);
        bus.A = 4'd5;
        bus.FETCH = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (bus.PCEN) pulses++;
            bus.A = 4'd6;
        end
        bus.FETCH = 1'b0;
        chk("hlt_pcen",  32'(pulses), 32'd0);
        chk("hlt_HALT",  {31'd0, bus.HALT}, 32'd1);
        chk("hlt_READY", {31'd0, bus.READY}, 32'd1);
        chk("hlt_IR",    {24'd0, bus.IR}, 32'hF0);
        chk("hlt_BUSY",  {31'd0, bus.BUSY}, 32'd0);
        pulse_reset();
        chk("hlt_clr_HALT", {31'd0, bus.HALT}, 32'd0);
        chk("hlt_clr_IR",   {24'd0, bus.IR}, 32'h0);

        // Memory persists across reset
        fetch_once(4'd4);
        chk("persist_IR", {24'd0, bus.IR}, 32'h4C);

        repeat (2) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
